// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 7-channel round-robin mux arbiter.
//   N_CH    : number of requesting channels (select code 3'b111 unused)
//   SEL_W   : width of the encoded channel select
//   state_t : arbiter FSM state encoding
//   inc_mod7: advance a channel index, wrapping 6 -> 0
package mux_arb_pkg;

  localparam int N_CH  = 7;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] inc_mod7(input logic [SEL_W-1:0] s);
    return (s == 3'd6) ? 3'd0 : s + 3'd1;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// wrapping 6 -> 0.
//   req     : per-channel requests
//   ptr     : highest-priority channel this round (0..6)
//   pick    : chosen channel (meaningful only when any_req=1)
//   any_req : at least one request is set
module rr_priority_pick
  import mux_arb_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any_req
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [SEL_W-1:0]  off;
  logic [SEL_W:0]    sum;

  // Doubling the vector turns the circular rotate into a plain shift:
  // rot[i] = req[(ptr+i) mod 7].
  assign dbl = {req, req};
  assign rot = N_CH'(dbl >> ptr);

  // Descending scan so the lowest set offset wins.
  always_comb begin
    off = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (rot[i]) off = SEL_W'(i);
  end

  assign sum     = {1'b0, ptr} + {1'b0, off};
  assign pick    = (sum >= (SEL_W+1)'(N_CH)) ? SEL_W'(sum - (SEL_W+1)'(N_CH))
                                             : sum[SEL_W-1:0];
  assign any_req = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 7-to-1 switch mux select. Grants one
// requester at a time, bounds hold time to MAX_HOLD cycles when others are
// waiting, and registers the selected data bit.
//   clock, resetn : clock (rising edge), async active-low reset
//   req           : level-sensitive per-channel requests
//   data_in       : per-channel data bits
//   grant         : registered one-hot grant (0 when idle)
//   sel           : registered encoded grant (0 when idle)
//   grant_valid   : grant active
//   data_out      : registered data_in[sel] while granted, else 0
//   preempt       : one-cycle pulse when a grant ends by timeout
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  data_in,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] sel,
  output logic             grant_valid,
  output logic             data_out,
  output logic             preempt
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel_n, pick;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_CH-1:0]  grant_n;
  logic             any_req, preempt_n, data_n;

  rr_priority_pick u_pick (
    .req     (req),
    .ptr     (ptr),
    .pick    (pick),
    .any_req (any_req)
  );

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    grant_n   = grant;
    sel_n     = sel;
    preempt_n = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_n = GRANT;
          grant_n = N_CH'(1) << pick;
          sel_n   = pick;
          cnt_n   = CNT_W'(1);
        end else begin
          grant_n = '0;
          sel_n   = '0;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        // Release outranks timeout, so a simultaneous drop never pulses preempt.
        if (!req[sel]) begin
          state_n = IDLE;
          grant_n = '0;
          sel_n   = '0;
          cnt_n   = '0;
          ptr_n   = inc_mod7(sel);
        end else if (cnt == HOLD_LIM && |(req & ~grant)) begin
          state_n   = IDLE;
          grant_n   = '0;
          sel_n     = '0;
          cnt_n     = '0;
          ptr_n     = inc_mod7(sel);
          preempt_n = 1'b1;
        end else if (cnt != HOLD_LIM) begin
          // Saturates so a sole requester keeps the grant indefinitely.
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    data_n = (state_n == GRANT) ? data_in[sel_n] : 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      grant    <= '0;
      sel      <= '0;
      data_out <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      grant    <= grant_n;
      sel      <= sel_n;
      data_out <= data_n;
      preempt  <= preempt_n;
    end
  end

  assign grant_valid = (state == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  logic       clock = 1'b0;
  logic       resetn;
  logic [6:0] req, data_in, grant;
  logic [2:0] sel;
  logic       grant_valid, data_out, preempt;

  int n_cmp = 0;
  int n_err = 0;

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .req         (req),
    .data_in     (data_in),
    .grant       (grant),
    .sel         (sel),
    .grant_valid (grant_valid),
    .data_out    (data_out),
    .preempt     (preempt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the full output set against an idle/grant expectation.
  task automatic chk_all(input string tag, input logic [6:0] g, input logic [2:0] s,
                         input logic gv, input logic d, input logic p);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".sel"}, 32'(sel), 32'(s));
    chk({tag, ".gv"}, 32'(grant_valid), 32'(gv));
    chk({tag, ".dout"}, 32'(data_out), 32'(d));
    chk({tag, ".pre"}, 32'(preempt), 32'(p));
  endtask

  initial begin
    logic [6:0] oh;
    logic [2:0] ch;
    logic [3:0] dseq;
    resetn  = 1'b0;
    req     = '0;
    data_in = '0;
    #3;
    chk_all("reset", 7'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); step();
    resetn = 1'b1;

    // Idle with no requests for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("idle", 7'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    end

    // Two requests from ptr=0: channel 2 first, then 4 after a dead cycle.
    req = 7'b0010100;
    step();
    chk_all("g2", 7'b0000100, 3'd2, 1'b1, 1'b0, 1'b0);
    req = 7'b0010000;
    step();
    chk_all("dead2", 7'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("g4", 7'b0010000, 3'd4, 1'b1, 1'b0, 1'b0);
    // Release 4 (ptr->5) with 0 and 6 pending: 6 must win.
    req = 7'b1000001;
    step();
    chk_all("dead4", 7'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("g6_ptr5", 7'b1000000, 3'd6, 1'b1, 1'b0, 1'b0);
    req = '0;
    step();
    chk_all("rel6", 7'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    // ptr wrapped to 0 after 6 released.

    // All requesting: rotate 0..6,0 with 8-cycle holds and a preempt dead cycle.
    req = 7'b1111111;
    step();
    for (int r = 0; r < 8; r++) begin
      ch = 3'(r % 7);
      oh = 7'b1 << ch;
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("rot%0d.grant", r), 32'(grant), 32'(oh));
        chk($sformatf("rot%0d.sel", r), 32'(sel), 32'(ch));
        chk($sformatf("rot%0d.pre", r), 32'(preempt), 32'd0);
        step();
      end
      chk($sformatf("rot%0d.deadg", r), 32'(grant), 32'd0);
      chk($sformatf("rot%0d.deadgv", r), 32'(grant_valid), 32'd0);
      chk($sformatf("rot%0d.deadpre", r), 32'(preempt), 32'd1);
      if (r == 7) req = '0;
      step();
    end
    chk_all("rot_end", 7'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Sole requester 6 is never preempted.
    req = 7'b1000000;
    for (int i = 0; i < 50; i++) begin
      step();
      chk($sformatf("sole%0d.grant", i), 32'(grant), 32'h40);
      chk($sformatf("sole%0d.pre", i), 32'(preempt), 32'd0);
    end
    req = '0;
    step();
    chk_all("sole_rel", 7'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    // ptr wrapped to 0: with 0 and 6 pending, 0 wins.
    req = 7'b1000001;
    step();
    chk_all("wrap0", 7'b0000001, 3'd0, 1'b1, 1'b0, 1'b0);
    req = '0;
    step();
    chk_all("rel0", 7'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Data path on channel 3; channel 5 data toggles as a distractor.
    req = 7'b0001000;
    step();
    chk_all("g3", 7'b0001000, 3'd3, 1'b1, 1'b0, 1'b0);
    dseq = 4'b0110;  // applied LSB first: 0,1,1,0
    for (int i = 0; i < 4; i++) begin
      data_in[3] = dseq[i];
      data_in[5] = ~dseq[i];
      step();
      chk($sformatf("dout%0d", i), 32'(data_out), 32'(dseq[i]));
    end
    data_in[5] = 1'b1;
    step();
    chk("dout_d5", 32'(data_out), 32'd0);
    data_in[3] = 1'b1;
    req = '0;
    step();
    chk_all("rel3", 7'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Mid-grant async reset on channel 5 (data_in[5]=1 so data_out is set).
    req = 7'b0100000;
    step();
    chk_all("g5", 7'b0100000, 3'd5, 1'b1, 1'b1, 1'b0);
    step(); step();
    #2;
    resetn = 1'b0;
    #1;
    chk_all("async_rst", 7'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk_all("in_rst", 7'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    step();
    chk_all("post_rst_g5", 7'b0100000, 3'd5, 1'b1, 1'b1, 1'b0);

    // Second reset: ptr restarts at 0, so 0 beats 5.
    resetn = 1'b0;
    req    = 7'b0100001;
    data_in = '0;
    step();
    resetn = 1'b1;
    step();
    chk_all("ptr_rst", 7'b0000001, 3'd0, 1'b1, 1'b0, 1'b0);

    // Release coinciding with timeout: treated as release, no preempt.
    req = 7'b0000011;
    for (int i = 0; i < 7; i++) step();
    chk("to_hold", 32'(grant), 32'd1);
    req = 7'b0000010;
    step();
    chk_all("rel_to", 7'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("g1_after", 7'b0000010, 3'd1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
